// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone round-robin arbiter with a single slave port.
// Define WB_ARB_TIMEOUT_EN to add the no-ack timeout and ERR state.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [63:0] m_adr_i,
  input  logic [63:0] m_dat_i,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [31:0] m_dat_o,
  output logic [1:0]  gnt_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN, ERR} state_e;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE, OWN} state_e;
`endif

  state_e     state_q;
  logic [1:0] gnt_q;
  logic       last_q;
  logic [1:0] pick;
  logic       g;
  logic       own;

  assign g     = gnt_q[1];
  assign own   = (state_q == OWN);
  assign gnt_o = gnt_q;

  // On a tie the master not granted last wins.
  always_comb begin
    pick = m_cyc_i;
    if (m_cyc_i == 2'b11)
      pick = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            gnt_q   <= pick;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (!m_cyc_i[g]) begin
            state_q <= IDLE;
            last_q  <= g;
            gnt_q   <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
          end else if (s_ack_i) begin
            cnt_q <= 8'd0;
          end else if (s_stb_o) begin
            if (cnt_q == TO_LAST) begin
              state_q <= ERR;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
`endif
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ERR: begin
          if (!m_cyc_i[g]) begin
            state_q <= IDLE;
            last_q  <= g;
            gnt_q   <= 2'b00;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // Slave side follows the owner combinationally; quiet otherwise.
  always_comb begin
    s_cyc_o = own & m_cyc_i[g];
    s_stb_o = own & m_stb_i[g];
    s_we_o  = own & m_we_i[g];
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    m_ack_o = 2'b00;
    m_dat_o = 32'd0;
    if (own) begin
      s_adr_o = g ? m_adr_i[63:32] : m_adr_i[31:0];
      s_dat_o = g ? m_dat_i[63:32] : m_dat_i[31:0];
      m_ack_o = s_ack_i ? gnt_q : 2'b00;
      m_dat_o = s_dat_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign m_err_o = (state_q == ERR) ? (gnt_q & m_stb_i) : 2'b00;
`else
  assign m_err_o = 2'b00;
`endif

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of cycles without an acknowledge, counted from strobe, before the bus cycle is aborted (range 2..255).
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 m_cyc_i  input  2  per-master cycle request; bit n is master n.
REQ-005 m_stb_i  input  2  per-master strobe.
REQ-006 m_we_i  input  2  per-master write enable.
REQ-007 m_adr_i  input  64  master n address in bits [32n+31:32n].
REQ-008 m_dat_i  input  64  master n write data in bits [32n+31:32n].
REQ-009 m_ack_o  output  2  per-master acknowledge.
REQ-010 m_err_o  output  2  per-master error termination.
REQ-011 m_dat_o  output  32  read data broadcast to both masters; valid only for the granted master.
REQ-012 gnt_o  output  2  one-hot current grant; 2'b00 when the bus is idle.
REQ-013 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side cycle, strobe and write enable.
REQ-014 s_adr_o, s_dat_o  output  32 each  slave-side address and write data.
REQ-015 s_ack_i  input  1  slave acknowledge; the slave may hold it high until strobe drops.
REQ-016 s_dat_i  input  32  slave read data.

Function
REQ-017 The FSM shall have the states IDLE and OWN, plus ERR when WB_ARB_TIMEOUT_EN is defined.
REQ-018 IDLE: if any m_cyc_i bit is high, the FSM shall register a grant and move to OWN; arbitration latency is 1 cycle (gnt_o is valid the cycle after the request).
REQ-019 Arbitration shall be round-robin: with a single requester, that master wins; when both request in the same cycle, the master not granted last (last_gnt) wins.
REQ-020 OWN: s_cyc_o, s_stb_o, s_we_o, s_adr_o and s_dat_o shall combinationally follow the granted master's inputs; m_ack_o[g] = s_ack_i; m_dat_o = s_dat_i.
REQ-021 The non-granted master shall see m_ack_o=0 and m_err_o=0 and is stalled; grants shall never be preempted.
REQ-022 OWN exit: when the granted master's m_cyc_i is low, the FSM shall go to IDLE, set last_gnt <= g and clear gnt_o; gaps between cycles of the same master (stb toggling, cyc held) shall not release the grant.
REQ-023 In IDLE, all s_*_o outputs shall be 0, and m_ack_o, m_err_o and m_dat_o shall be 0.
REQ-024 A request raised in the same cycle the owner drops cyc shall be arbitrated from IDLE on the next cycle, so back-to-back ownership costs 1 idle cycle.

Reset
REQ-025 With rst_i high at a clock edge, the block shall set state=IDLE, gnt_o=0, last_gnt=1 (master 0 wins the first tie) and the timeout counter to 0.
REQ-026 A reset during OWN or ERR shall drive s_cyc_o and s_stb_o to 0 from the cycle after the reset edge, with no ack or err issued to the aborted master.

Configuration
REQ-027 With macro WB_ARB_TIMEOUT_EN defined, an 8-bit counter shall increment each OWN cycle with s_stb_o=1 and s_ack_i=0, and clear on ack or on leaving OWN.
REQ-028 When the counter reaches TIMEOUT-1 with no ack, the FSM shall enter ERR: s_cyc_o=s_stb_o=0 and m_err_o[g]=m_stb_i[g]; ERR shall exit to IDLE when m_cyc_i[g] drops, updating last_gnt.
REQ-029 Without WB_ARB_TIMEOUT_EN, there shall be no ERR state and no counter, m_err_o shall be tied to 0, TIMEOUT shall be unused, and a hung slave stalls the bus indefinitely.

Verification
REQ-030 Reset, then master 0 read (cyc/stb=1, we=0), with the slave returning 32'hBBBB0000 and ack two cycles later -> gnt_o=01 the cycle after the request; m_ack_o=01; m_dat_o=32'hBBBB0000.
REQ-031 Both masters raise cyc in the same cycle after reset -> master 0 granted; after it drops cyc, 1 idle cycle, then gnt_o=10.
REQ-032 Master 1 holds cyc across three strobes while master 0 requests -> gnt_o stays 10 until master 1 drops cyc; master 0 never sees ack.
REQ-033 rst_i asserted mid-OWN with the slave ack pending -> next cycle gnt_o=00 and s_cyc_o=0; m_ack_o and m_err_o stay 0.
REQ-034 With WB_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks -> m_err_o[g]=1 in the 5th cycle after stb, with s_stb_o=0; without the macro -> m_err_o stays 0 and the grant is held.
